// File: rtl/host_test_monitor.sv
// host_test_monitor
//
// Sits beside the core and turns its tohost writes into a registered
// pass / fail / timeout verdict, while a watchdog counts cycles spent in RUN.
// Every store the core issues while the test is running is recorded in a
// small show-ahead trace FIFO that a host or FPGA debug logic can drain after
// the test has finished.
//
// Optional feature macro: HOST_MON_CYCLE_STAMP_EN
//   defined   -> each trace entry also records cycle_count at push time and
//                presents it on trace_cycle
//   undefined -> no stamp storage is built and trace_cycle is tied to 0
module host_test_monitor #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TRACE_DEPTH    = 16,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int CNT_W          = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           host_write_enable,
    input  logic [XLEN-1:0]                host_data_out,
    input  logic                           st_valid,
    input  logic [ADDR_W-1:0]              st_addr,
    input  logic [XLEN-1:0]                st_data,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [XLEN-2:0]                fail_code,
    output logic [CNT_W-1:0]               cycle_count,
    output logic                           trace_valid,
    output logic [ADDR_W-1:0]              trace_addr,
    output logic [XLEN-1:0]                trace_data,
    output logic [CNT_W-1:0]               trace_cycle,
    input  logic                           trace_rd_en,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_overflow
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);

    // Last RUN cycle value before the watchdog fires (compared pre-increment).
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_C      = (PTR_W + 1)'(TRACE_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Verdict state machine and cycle counter
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic [XLEN-2:0]    failCode_q, failCode_d;
    logic [CNT_W-1:0]   cycleCount_q, cycleCount_d;

    // Register the verdict, the sticky status outputs and the RUN cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            failCode_q   <= '0;
            cycleCount_q <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            failCode_q   <= failCode_d;
            cycleCount_q <= cycleCount_d;
        end
    end

    // Decide the next verdict; a host write takes priority over the watchdog, and terminal states hold everything.
    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        failCode_d   = failCode_q;
        cycleCount_d = cycleCount_q;

        case (state_q)
            ST_RUN: begin
                cycleCount_d = cycleCount_q + CNT_W'(1);
                if (host_write_enable) begin
                    done_d = 1'b1;
                    if (host_data_out[0]) begin
                        state_d    = ST_PASS;
                        pass_d     = 1'b1;
                        failCode_d = '0;
                    end else begin
                        state_d    = ST_FAIL;
                        pass_d     = 1'b0;
                        failCode_d = host_data_out[XLEN-1:1];
                    end
                end else if (cycleCount_q == TIMEOUT_LAST) begin
                    state_d   = ST_TIMEOUT;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign fail_code   = failCode_q;
    assign cycle_count = cycleCount_q;

    // ------------------------------------------------------------------
    // Store trace FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  addrMem [TRACE_DEPTH];
    logic [XLEN-1:0]    dataMem [TRACE_DEPTH];

    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;

    logic               pushReq;
    logic               pushEn;
    logic               popEn;
    logic               fifoFull;
    logic               fifoEmpty;

    // Work out push/pop for this cycle; a full FIFO only accepts a store when the head is popped at the same time.
    always_comb begin
        fifoFull   = (count_q == DEPTH_C);
        fifoEmpty  = (count_q == '0);
        pushReq    = st_valid && (state_q == ST_RUN);
        popEn      = trace_rd_en && !fifoEmpty;
        pushEn     = pushReq && (!fifoFull || popEn);

        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end

        case ({pushEn, popEn})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (pushReq && fifoFull && !popEn) begin
            overflow_d = 1'b1;
        end

        valid_d = (count_d != '0);
    end

    // Register FIFO pointers, occupancy, head-valid and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Write accepted stores into the trace storage; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            addrMem[wrPtr_q] <= st_addr;
            dataMem[wrPtr_q] <= st_data;
        end
    end

    assign trace_valid    = valid_q;
    assign trace_count    = count_q;
    assign trace_overflow = overflow_q;

    // Head entry is read straight from storage and forced to zero while the FIFO is empty.
    assign trace_addr = valid_q ? addrMem[rdPtr_q] : '0;
    assign trace_data = valid_q ? dataMem[rdPtr_q] : '0;

`ifdef HOST_MON_CYCLE_STAMP_EN
    logic [CNT_W-1:0] cycleMem [TRACE_DEPTH];

    // Record the RUN cycle on which each accepted store was seen.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            cycleMem[wrPtr_q] <= cycleCount_q;
        end
    end

    assign trace_cycle = valid_q ? cycleMem[rdPtr_q] : '0;
`else
    assign trace_cycle = '0;
`endif

endmodule

// File: doc/host_test_monitor.md
Name: host_test_monitor

Overview:
- Synthesizable successor to the simulation pass/fail checker for riscv_core.
- Sits beside the core. Watches the core's tohost write port and store bus, and runs a cycle watchdog.
- Decodes the test result as pass, fail code or timeout.
- Captures a parametrised-depth trace of store events that a host or FPGA debug logic reads out after the test ends.

Parameters:
XLEN, 32, width of host data and store data
ADDR_W, 32, width of store address
TRACE_DEPTH, 16, store-trace FIFO entries; power of two, >= 2
TIMEOUT_CYCLES, 500000, cycles in RUN before timeout is declared; >= 1
CNT_W, 32, width of the cycle counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
host_write_enable  in  1  core writes tohost this cycle
host_data_out  in  XLEN  tohost value
st_valid  in  1  core store this cycle
st_addr  in  ADDR_W  store address
st_data  in  XLEN  store data
done  out  1  test finished (pass, fail or timeout)
pass  out  1  tohost bit0 was 1
timeout  out  1  watchdog expired
fail_code  out  XLEN-1  host_data_out[XLEN-1:1] of a failing write
cycle_count  out  CNT_W  cycles spent in RUN
trace_valid  out  1  FIFO non-empty; head entry presented
trace_addr  out  ADDR_W  head entry address
trace_data  out  XLEN  head entry data
trace_cycle  out  CNT_W  head entry cycle stamp (see feature)
trace_rd_en  in  1  pop head entry
trace_count  out  clog2(TRACE_DEPTH)+1  entries held
trace_overflow  out  1  sticky: a store was dropped because the FIFO was full

Behaviour:
- Reset (rst low, async):
  - State goes to RUN.
  - All outputs 0; cycle_count 0; FIFO empty.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until reset.
- RUN, every cycle:
  - cycle_count increments by 1.
  - Watchdog compare uses the pre-increment value.
- RUN with host_write_enable=1:
  - host_data_out[0]=1 -> PASS: next cycle done=1, pass=1, fail_code=0.
  - host_data_out[0]=0 -> FAIL: next cycle done=1, pass=0, fail_code=host_data_out>>1.
- RUN with cycle_count==TIMEOUT_CYCLES-1 and no host write -> TIMEOUT: next cycle done=1, timeout=1.
  - If a host write arrives in the same cycle, the host write wins.
- Terminal states:
  - cycle_count frozen.
  - host_write_enable and st_valid ignored.
  - FIFO still readable.
- Trace FIFO (show-ahead):
  - Push when st_valid=1 in RUN; the entry is visible on trace_* the next cycle.
  - trace_rd_en with trace_valid=1 pops; trace_rd_en on empty is ignored.
  - Full with push and no pop: store dropped, trace_overflow set, sticky until reset.
  - Full with push and pop in the same cycle: both performed, count unchanged, no overflow.
  - Empty with push and pop in the same cycle: pop ignored, push accepted.
  - Pointers wrap modulo TRACE_DEPTH.
- All outputs are registered except trace_* head data, which reads combinationally from storage at the read pointer.

Optional Feature:
- Macro HOST_MON_CYCLE_STAMP_EN:
  - Defined: each pushed entry also stores cycle_count at push time; trace_cycle presents it.
  - Undefined: no stamp storage is built; trace_cycle is tied to 0.

Test Plan:
- Reset, then host write 0x00000001 at RUN cycle 10 -> next cycle done=1, pass=1, timeout=0, fail_code=0, cycle_count=11 and frozen thereafter.
- Host write 0x0000000A -> done=1, pass=0, fail_code=0x5; a later write of 0x1 is ignored (pass stays 0).
- TIMEOUT_CYCLES=20, no host write -> at cycle 20 done=1, timeout=1, pass=0. Repeat with a host write of 0x1 exactly at cycle_count=19 -> pass=1, timeout=0.
- TRACE_DEPTH=4, stores (0x100,0xA)..(0x114,0xF), six stores, no reads:
  - trace_count=4, trace_overflow=1.
  - Pops return 0x100/0xA, 0x104/0xB, 0x108/0xC, 0x10C/0xD, then trace_valid=0.
- Full FIFO, st_valid and trace_rd_en in the same cycle -> count stays 4, overflow stays 0, new entry is read last.
- Assert rst low mid-run with 3 entries held -> immediately done=0, trace_count=0, trace_valid=0, cycle_count=0.
  - With HOST_MON_CYCLE_STAMP_EN, after release a store at RUN cycle 5 reads trace_cycle=5.
